// File: rtl/cordic_result_fp_pipe_if.sv
// Handshake bundle between the CORDIC core, the fixed-to-float back end and its consumer.
interface cordic_result_fp_pipe_if #(
    parameter int WIDTH = 21
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] fixed_in;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      result;

    modport master (
        output in_valid, fixed_in, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, fixed_in, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/cordic_result_fp_pipe.sv
// Three-stage signed Q1.FRAC to IEEE-754 single converter with global-stall handshake.
// Optional flush-to-zero of tiny results is enabled by defining CORDIC_FTZ_EN.
module cordic_result_fp_pipe #(
    parameter int WIDTH    = 21,
    parameter int FRAC     = 20,
    parameter int FTZ_BITS = 16
) (
    input  logic                      clock,
    input  logic                      aclr_n,
    input  logic                      clk_en,
    cordic_result_fp_pipe_if.slave    bus
);
    localparam int              PW       = $clog2(WIDTH);
    localparam logic [7:0]      EXP_BASE = 8'(127 - FRAC);

    if (WIDTH != FRAC + 1) begin : g_bad_width
        $error("cordic_result_fp_pipe: WIDTH must equal FRAC+1");
    end
    if (FRAC > 23) begin : g_bad_frac
        $error("cordic_result_fp_pipe: FRAC must not exceed 23");
    end
    if (FTZ_BITS > FRAC) begin : g_bad_ftz
        $error("cordic_result_fp_pipe: FTZ_BITS must not exceed FRAC");
    end

    logic             advance;
    logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic             sign1_q, sign1_d, sign2_q, sign2_d;
    logic [WIDTH-1:0] mag1_q, mag1_d, mag2_q, mag2_d;
    logic             zero2_q, zero2_d;
    logic [PW-1:0]    p2_q, p2_d;
    logic [31:0]      result_q, result_d;

    logic [WIDTH-1:0] mag_in;
    logic [PW-1:0]    lead_p;
    logic [23:0]      mant_ext;
    logic [7:0]       exp_val;
    logic [31:0]      conv;

    // Leading-one search; the highest set bit wins because later iterations overwrite.
    always_comb begin
        lead_p = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (mag1_q[i]) lead_p = PW'(i);
        end
    end

    always_comb begin
        mag_in   = bus.fixed_in[WIDTH-1] ? (~bus.fixed_in + 1'b1) : bus.fixed_in;
        exp_val  = EXP_BASE + 8'(p2_q);
        mant_ext = 24'(mag2_q) << (5'd23 - 5'(p2_q));
        conv     = zero2_q ? 32'h0000_0000 : {sign2_q, exp_val, mant_ext[22:0]};
`ifdef CORDIC_FTZ_EN
        if (mag2_q < (WIDTH'(1) << (FRAC - FTZ_BITS))) conv = 32'h0000_0000;
`endif
    end

    always_comb begin
        advance  = clk_en & (~v3_q | bus.out_ready);
        v1_d     = v1_q;
        v2_d     = v2_q;
        v3_d     = v3_q;
        sign1_d  = sign1_q;
        mag1_d   = mag1_q;
        sign2_d  = sign2_q;
        mag2_d   = mag2_q;
        zero2_d  = zero2_q;
        p2_d     = p2_q;
        result_d = result_q;
        if (advance) begin
            v1_d = bus.in_valid;
            v2_d = v1_q;
            v3_d = v2_q;
            if (bus.in_valid) begin
                sign1_d = bus.fixed_in[WIDTH-1];
                mag1_d  = mag_in;
            end
            if (v1_q) begin
                sign2_d = sign1_q;
                mag2_d  = mag1_q;
                zero2_d = (mag1_q == '0);
                p2_d    = lead_p;
            end
            if (v2_q) begin
                result_d = conv;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!aclr_n) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            sign1_q  <= 1'b0;
            mag1_q   <= '0;
            sign2_q  <= 1'b0;
            mag2_q   <= '0;
            zero2_q  <= 1'b0;
            p2_q     <= '0;
            result_q <= '0;
        end else begin
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            v3_q     <= v3_d;
            sign1_q  <= sign1_d;
            mag1_q   <= mag1_d;
            sign2_q  <= sign2_d;
            mag2_q   <= mag2_d;
            zero2_q  <= zero2_d;
            p2_q     <= p2_d;
            result_q <= result_d;
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = v3_q;
    assign bus.result    = result_q;
endmodule

// File: tb/tb_cordic_result_fp_pipe.sv
// Directed bench for cordic_result_fp_pipe: hand-computed vectors, stalls, clk_en and reset.
module tb_cordic_result_fp_pipe;
    localparam int WIDTH = 21;

`ifdef CORDIC_FTZ_EN
    localparam logic [31:0] E_NEG_LSB = 32'h0000_0000;
    localparam logic [31:0] E_POS_LSB = 32'h0000_0000;
    localparam logic [31:0] E_TWO_LSB = 32'h0000_0000;
`else
    localparam logic [31:0] E_NEG_LSB = 32'hB580_0000;
    localparam logic [31:0] E_POS_LSB = 32'h3580_0000;
    localparam logic [31:0] E_TWO_LSB = 32'h3600_0000;
`endif

    logic clock = 1'b0;
    logic aclr_n;
    logic clk_en;

    cordic_result_fp_pipe_if #(.WIDTH(WIDTH)) bif ();

    cordic_result_fp_pipe #(.WIDTH(WIDTH), .FRAC(20), .FTZ_BITS(16)) dut (
        .clock  (clock),
        .aclr_n (aclr_n),
        .clk_en (clk_en),
        .bus    (bif)
    );

    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_out = 0;
    logic        acc_flag;
    logic [31:0] cur_exp;
    logic [31:0] exp_q[$];
    logic [31:0] snap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Called at posedge+1 after inputs are driven; records transfers, then advances one edge.
    task automatic tick();
        #1;
        acc_flag = aclr_n && bif.in_valid && bif.in_ready;
        if (acc_flag) exp_q.push_back(cur_exp);
        if (aclr_n && clk_en && bif.out_valid && bif.out_ready) begin
            chk("out_has_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("out_result", bif.result, exp_q.pop_front());
            n_out++;
        end
        @(posedge clock);
        #1;
    endtask

    // Latency counts edges from the accepting edge inclusive: valid after the third.
    task automatic latency_check(input logic [WIDTH-1:0] w, input logic [31:0] e);
        int lat;
        bif.in_valid = 1'b1;
        bif.fixed_in = w;
        cur_exp      = e;
        tick();
        chk("lat_accepted", 32'(acc_flag), 32'd1);
        bif.in_valid = 1'b0;
        lat = 1;
        while (!bif.out_valid && lat < 8) begin
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 32'd3);
        tick();
    endtask

    logic [WIDTH-1:0] vin [9] = '{21'h09B74E, 21'h080000, 21'h100000, 21'h000000, 21'h0FFFFF,
                                  21'h000001, 21'h1FFFFF, 21'h000010, 21'h180000};
    logic [31:0]      vexp[9] = '{32'h3F1B74E0, 32'h3F000000, 32'hBF800000, 32'h00000000,
                                  32'h3F7FFFF0, E_POS_LSB, E_NEG_LSB, 32'h37800000, 32'hBF000000};
    logic [WIDTH-1:0] bin [5] = '{21'h040000, 21'h1C0000, 21'h020000, 21'h0C0000, 21'h000002};
    logic [31:0]      bexp[5] = '{32'h3E800000, 32'hBE800000, 32'h3E000000, 32'h3F400000, E_TWO_LSB};

    initial begin
        int k;
        int base;
        aclr_n        = 1'b0;
        clk_en        = 1'b1;
        bif.in_valid  = 1'b1;
        bif.fixed_in  = 21'h0FFFFF;
        bif.out_ready = 1'b1;
        cur_exp       = 32'h0;

        // Reset held two cycles with a valid word presented
        tick();
        chk("rst1_out_valid", 32'(bif.out_valid), 32'd0);
        chk("rst1_result", bif.result, 32'h0);
        tick();
        chk("rst2_out_valid", 32'(bif.out_valid), 32'd0);
        chk("rst2_result", bif.result, 32'h0);
        exp_q.delete();
        aclr_n = 1'b1;
        latency_check(21'h09B74E, 32'h3F1B74E0);

        // Value table streamed back to back
        base = n_out;
        for (int i = 0; i < 9; i++) begin
            bif.in_valid = 1'b1;
            bif.fixed_in = vin[i];
            cur_exp      = vexp[i];
            tick();
        end
        bif.in_valid = 1'b0;
        repeat (5) tick();
        chk("values_count", 32'(n_out - base), 32'd9);

        // Backpressure: consumer stalled for 6 cycles
        base = n_out;
        bif.out_ready = 1'b0;
        k = 0;
        repeat (6) begin
            bif.in_valid = (k < 5);
            bif.fixed_in = bin[k % 5];
            cur_exp      = bexp[k % 5];
            tick();
            if (acc_flag) k++;
        end
        chk("bp_accepted", 32'(k), 32'd3);
        #1;
        chk("bp_in_ready", 32'(bif.in_ready), 32'd0);
        chk("bp_out_valid", 32'(bif.out_valid), 32'd1);
        chk("bp_head", bif.result, 32'h3E800000);
        snap = bif.result;
        repeat (2) tick();
        chk("bp_stable", bif.result, snap);
        bif.out_ready = 1'b1;
        for (int c = 0; c < 10 && k < 5; c++) begin
            bif.in_valid = 1'b1;
            bif.fixed_in = bin[k];
            cur_exp      = bexp[k];
            tick();
            if (acc_flag) k++;
        end
        bif.in_valid = 1'b0;
        repeat (6) tick();
        chk("bp_count", 32'(n_out - base), 32'd5);

        // clk_en low with a full pipe
        base = n_out;
        for (int i = 0; i < 3; i++) begin
            bif.in_valid = 1'b1;
            bif.fixed_in = vin[i];
            cur_exp      = vexp[i];
            tick();
        end
        bif.in_valid = 1'b0;
        clk_en = 1'b0;
        snap = bif.result;
        chk("ce_head", snap, 32'h3F1B74E0);
        repeat (4) begin
            tick();
            chk("ce_in_ready", 32'(bif.in_ready), 32'd0);
            chk("ce_out_valid", 32'(bif.out_valid), 32'd1);
            chk("ce_result", bif.result, snap);
        end
        clk_en = 1'b1;
        repeat (6) tick();
        chk("ce_count", 32'(n_out - base), 32'd3);

        // Reset while all three stages hold data
        for (int i = 0; i < 3; i++) begin
            bif.in_valid = 1'b1;
            bif.fixed_in = bin[i];
            cur_exp      = bexp[i];
            tick();
        end
        bif.in_valid = 1'b0;
        aclr_n = 1'b0;
        tick();
        aclr_n = 1'b1;
        exp_q.delete();
        chk("mid_rst_out_valid", 32'(bif.out_valid), 32'd0);
        chk("mid_rst_result", bif.result, 32'h0);
        repeat (4) begin
            tick();
            chk("mid_rst_no_stale", 32'(bif.out_valid), 32'd0);
        end
        latency_check(21'h180000, 32'hBF000000);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
